// File: rtl/ps2_scancode_decoder.sv
// Assembles PS/2 Scan Code Set 2 byte sequences (E0/F0 prefixes, Pause, status bytes) into key events.
// Define PS2_ASCII_EN to add shift tracking and ASCII translation of make events.
module ps2_scancode_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  PAUSE_CODE     = 8'hE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       key_valid,
    output logic [7:0] ascii
);

    localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t        state, state_next, cur_state;
    logic [TW-1:0] to_cnt;
    logic [2:0]    pause_cnt, pause_next;
    logic          expired;
    logic          emit, emit_ext, emit_rel;
    logic [7:0]    emit_code, ascii_next;

    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == 8'hE0) || (b == 8'hF0);
    endfunction

    // An expired sequence is treated as IDLE in the same cycle, so a byte
    // arriving exactly at expiry starts a fresh sequence.
    assign expired   = (state != IDLE) && (to_cnt == TO_LAST);
    assign cur_state = expired ? IDLE : state;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = cur_state;
        pause_next = pause_cnt;
        emit       = 1'b0;
        emit_code  = rx_data;
        emit_ext   = 1'b0;
        emit_rel   = 1'b0;
        if (rx_valid) begin
            case (cur_state)
                IDLE: begin
                    if (rx_data == 8'hE0)      state_next = EXT;
                    else if (rx_data == 8'hF0) state_next = BRK;
                    else if (rx_data == 8'hE1) begin
                        state_next = PAUSE;
                        pause_next = 3'd7;
                    end else begin
                        emit = !is_status(rx_data);
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0)      state_next = EXT_BRK;
                    else if (rx_data != 8'hE0) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    emit       = !is_prefix(rx_data);
                    emit_rel   = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    emit       = !is_prefix(rx_data);
                    emit_ext   = 1'b1;
                    emit_rel   = 1'b1;
                    state_next = IDLE;
                end
                PAUSE: begin
                    pause_next = pause_cnt - 3'd1;
                    if (pause_cnt == 3'd1) begin
                        emit       = 1'b1;
                        emit_code  = PAUSE_CODE;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            to_cnt    <= '0;
            pause_cnt <= '0;
        end else begin
            state     <= state_next;
            pause_cnt <= pause_next;
            if (rx_valid || cur_state == IDLE) to_cnt <= '0;
            else if (to_cnt != TO_LAST)        to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_extended <= 1'b0;
            key_released <= 1'b0;
            ascii        <= '0;
        end else begin
            key_valid <= emit;
            if (emit) begin
                key_code     <= emit_code;
                key_extended <= emit_ext;
                key_released <= emit_rel;
                ascii        <= ascii_next;
            end
        end
    end

`ifdef PS2_ASCII_EN
    logic shift_l, shift_r;

    function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic shift);
        logic [4:0] idx;
        logic       hit;
        hit = 1'b1;
        idx = 5'd0;
        case (code)
            8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
            8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
            8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
            8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
            8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
            8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
            8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
            default: hit = 1'b0;
        endcase
        if (hit) return (shift ? 8'h41 : 8'h61) + {3'b000, idx};
        case (code)
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;  8'h26: return 8'h33;
            8'h25: return 8'h34;  8'h2E: return 8'h35;  8'h36: return 8'h36;  8'h3D: return 8'h37;
            8'h3E: return 8'h38;  8'h46: return 8'h39;
            8'h29: return 8'h20;  8'h5A: return 8'h0A;  8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    assign ascii_next = (emit_ext || emit_rel) ? 8'h00 : to_ascii(emit_code, shift_l | shift_r);

    // Only non-extended shift events move the flags; E0-prefixed 12 is a fake shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (emit && !emit_ext) begin
            if (emit_code == 8'h12) shift_l <= !emit_rel;
            if (emit_code == 8'h59) shift_r <= !emit_rel;
        end
    end
`else
    assign ascii_next = 8'h00;
`endif

endmodule
